// File: rtl/snake_pkg.sv
// Shared definitions for the snake body engine.
// Contents: direction encodings, FSM state type, default grid and coordinate
// sizes, and a helper that returns the 180-degree opposite of a direction.
package snake_pkg;

  localparam int DEF_COORD_BIT = 7;
  localparam int DEF_GRID_W    = 80;
  localparam int DEF_GRID_H    = 60;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_CHECK,
    ST_HALT
  } state_t;

  function automatic logic [1:0] opposite_dir(input logic [1:0] dir);
    logic [1:0] opp;
    case (dir)
      DIR_RIGHT: opp = DIR_LEFT;
      DIR_LEFT:  opp = DIR_RIGHT;
      DIR_UP:    opp = DIR_DOWN;
      default:   opp = DIR_UP;
    endcase
    return opp;
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculator.
// Ports:
//   x, y           current head coordinates
//   dir            direction of travel (snake_pkg DIR_* encoding)
//   nx, ny         head coordinates after one step
//   out_of_bounds  step would leave the grid (never set when wrapping)
// Build option: define SNAKE_WRAP_AROUND_EN to wrap the head at the grid
// edges instead of reporting a wall hit.
module snake_next_head
  import snake_pkg::*;
#(
  parameter int COORD_BIT = DEF_COORD_BIT,
  parameter int GRID_W    = DEF_GRID_W,
  parameter int GRID_H    = DEF_GRID_H
) (
  input  logic [COORD_BIT-1:0] x,
  input  logic [COORD_BIT-1:0] y,
  input  logic [1:0]           dir,
  output logic [COORD_BIT-1:0] nx,
  output logic [COORD_BIT-1:0] ny,
  output logic                 out_of_bounds
);

  localparam logic [COORD_BIT-1:0] X_MAX = COORD_BIT'(GRID_W - 1);
  localparam logic [COORD_BIT-1:0] Y_MAX = COORD_BIT'(GRID_H - 1);
  localparam logic [COORD_BIT-1:0] ONE   = COORD_BIT'(1);

  // On a wall hit the coordinates are left at the current head so that the
  // caller sees a harmless value; it suppresses the shift anyway.
  always_comb begin
    nx            = x;
    ny            = y;
    out_of_bounds = 1'b0;
    case (dir)
      DIR_RIGHT: begin
        if (x >= X_MAX) begin
`ifdef SNAKE_WRAP_AROUND_EN
          nx = '0;
`else
          out_of_bounds = 1'b1;
`endif
        end else begin
          nx = x + ONE;
        end
      end
      DIR_LEFT: begin
        if (x == '0) begin
`ifdef SNAKE_WRAP_AROUND_EN
          nx = X_MAX;
`else
          out_of_bounds = 1'b1;
`endif
        end else begin
          nx = x - ONE;
        end
      end
      DIR_UP: begin
        if (y == '0) begin
`ifdef SNAKE_WRAP_AROUND_EN
          ny = Y_MAX;
`else
          out_of_bounds = 1'b1;
`endif
        end else begin
          ny = y - ONE;
        end
      end
      default: begin
        if (y >= Y_MAX) begin
`ifdef SNAKE_WRAP_AROUND_EN
          ny = '0;
`else
          out_of_bounds = 1'b1;
`endif
        end else begin
          ny = y + ONE;
        end
      end
    endcase
  end

endmodule

// File: rtl/snake_body_engine.sv
// Snake position store with self/wall collision checking.
// Ports:
//   clock_25, reset      clock and synchronous active-high reset
//   game_tik             single-cycle move strobe (ignored while busy/halted)
//   dir_req              requested direction (00 right, 01 left, 10 up, 11 down)
//   fruit_eaten          grow request, applied at the next move
//   rd_index             segment to read, 0 = head
//   rd_x, rd_y, rd_valid registered read result, one cycle after rd_index
//   snake_head_x/_y      current head position
//   snake_length         current number of segments
//   busy                 move or collision scan in progress
//   collision_detected   sticky collision flag, cleared only by reset
// Build option: SNAKE_WRAP_AROUND_EN selects wrap-around edges (no walls).
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int COORD_BIT        = DEF_COORD_BIT,
  parameter int SNAKE_LENGTH_BIT = 6,
  parameter int MAX_LENGTH       = 32,
  parameter int INIT_LENGTH      = 3,
  parameter int GRID_W           = DEF_GRID_W,
  parameter int GRID_H           = DEF_GRID_H,
  parameter int START_X          = 40,
  parameter int START_Y          = 30
) (
  input  logic                        clock_25,
  input  logic                        reset,
  input  logic                        game_tik,
  input  logic [1:0]                  dir_req,
  input  logic                        fruit_eaten,
  input  logic [SNAKE_LENGTH_BIT-1:0] rd_index,
  output logic [COORD_BIT-1:0]        rd_x,
  output logic [COORD_BIT-1:0]        rd_y,
  output logic                        rd_valid,
  output logic [COORD_BIT-1:0]        snake_head_x,
  output logic [COORD_BIT-1:0]        snake_head_y,
  output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
  output logic                        busy,
  output logic                        collision_detected
);

  localparam int IDX_W = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
  localparam logic [SNAKE_LENGTH_BIT-1:0] MAX_LEN_V  = SNAKE_LENGTH_BIT'(MAX_LENGTH);
  localparam logic [SNAKE_LENGTH_BIT-1:0] INIT_LEN_V = SNAKE_LENGTH_BIT'(INIT_LENGTH);
  localparam logic [SNAKE_LENGTH_BIT-1:0] LEN_ONE    = SNAKE_LENGTH_BIT'(1);

  state_t state, state_next;

  logic [COORD_BIT-1:0] seg_x [MAX_LENGTH];
  logic [COORD_BIT-1:0] seg_y [MAX_LENGTH];

  logic [1:0]                  cur_dir;
  logic [1:0]                  eff_dir;
  logic                        grow_pending;
  logic [SNAKE_LENGTH_BIT-1:0] scan_k;
  logic [IDX_W-1:0]            scan_ptr;
  logic [IDX_W-1:0]            rd_ptr;
  logic                        scan_hit;
  logic [COORD_BIT-1:0]        new_x;
  logic [COORD_BIT-1:0]        new_y;
  logic                        wall_hit;
  logic                        do_shift;
  logic                        set_collision;

  // A request for the exact reverse of the current heading is ignored.
  assign eff_dir = (dir_req == opposite_dir(cur_dir)) ? cur_dir : dir_req;

  snake_next_head #(
    .COORD_BIT (COORD_BIT),
    .GRID_W    (GRID_W),
    .GRID_H    (GRID_H)
  ) u_next_head (
    .x             (seg_x[0]),
    .y             (seg_y[0]),
    .dir           (eff_dir),
    .nx            (new_x),
    .ny            (new_y),
    .out_of_bounds (wall_hit)
  );

  // Indices are only used when below snake_length, so truncation is safe.
  assign scan_ptr = scan_k[IDX_W-1:0];
  assign rd_ptr   = rd_index[IDX_W-1:0];
  assign scan_hit = (seg_x[scan_ptr] == seg_x[0]) && (seg_y[scan_ptr] == seg_y[0]);

  assign snake_head_x = seg_x[0];
  assign snake_head_y = seg_y[0];

  always_ff @(posedge clock_25) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // The scan ends when k reaches the length, giving a busy window of
  // one MOVE cycle plus snake_length CHECK cycles when nothing is hit.
  always_comb begin
    state_next    = state;
    busy          = 1'b0;
    do_shift      = 1'b0;
    set_collision = 1'b0;
    case (state)
      ST_IDLE: begin
        if (game_tik && !collision_detected) state_next = ST_MOVE;
      end
      ST_MOVE: begin
        busy = 1'b1;
        if (wall_hit) begin
          set_collision = 1'b1;
          state_next    = ST_HALT;
        end else begin
          do_shift   = 1'b1;
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        busy = 1'b1;
        if (scan_k >= snake_length) begin
          state_next = ST_IDLE;
        end else if (scan_hit) begin
          set_collision = 1'b1;
          state_next    = ST_HALT;
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Body store, length and grow bookkeeping. A fruit arriving in the MOVE
  // cycle itself is kept for the following move.
  always_ff @(posedge clock_25) begin
    if (reset) begin
      for (int i = 0; i < MAX_LENGTH; i++) begin
        seg_x[i] <= COORD_BIT'(START_X - i);
        seg_y[i] <= COORD_BIT'(START_Y);
      end
      snake_length       <= INIT_LEN_V;
      cur_dir            <= DIR_RIGHT;
      grow_pending       <= 1'b0;
      collision_detected <= 1'b0;
      scan_k             <= LEN_ONE;
    end else begin
      if (do_shift) begin
        for (int i = 1; i < MAX_LENGTH; i++) begin
          seg_x[i] <= seg_x[i-1];
          seg_y[i] <= seg_y[i-1];
        end
        seg_x[0] <= new_x;
        seg_y[0] <= new_y;
        cur_dir  <= eff_dir;
      end
      if (do_shift && grow_pending) begin
        if (snake_length < MAX_LEN_V) snake_length <= snake_length + LEN_ONE;
        grow_pending <= fruit_eaten;
      end else if (fruit_eaten) begin
        grow_pending <= 1'b1;
      end
      if (state == ST_MOVE)       scan_k <= LEN_ONE;
      else if (state == ST_CHECK) scan_k <= scan_k + LEN_ONE;
      if (set_collision) collision_detected <= 1'b1;
    end
  end

  // Renderer read port, one cycle of latency.
  always_ff @(posedge clock_25) begin
    if (reset) begin
      rd_x     <= '0;
      rd_y     <= '0;
      rd_valid <= 1'b0;
    end else if (rd_index < snake_length) begin
      rd_x     <= seg_x[rd_ptr];
      rd_y     <= seg_y[rd_ptr];
      rd_valid <= 1'b1;
    end else begin
      rd_x     <= '0;
      rd_y     <= '0;
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_snake_body_engine.sv
// Self-checking bench for snake_body_engine. Expected move results and read
// results are queued by the stimulus from a list-based reference snake;
// independent monitors compare them when the DUT finishes a move (busy
// falling) or returns read data.
module tb_snake_body_engine;
  import snake_pkg::*;

  localparam int CB = 7;
  localparam int LB = 6;
  localparam int ML = 32;
  localparam int IL = 3;
  localparam int GW = 80;
  localparam int GH = 60;
  localparam int SX = 40;
  localparam int SY = 30;

  logic          clock_25 = 1'b0;
  logic          reset;
  logic          game_tik;
  logic [1:0]    dir_req;
  logic          fruit_eaten;
  logic [LB-1:0] rd_index;
  logic [CB-1:0] rd_x;
  logic [CB-1:0] rd_y;
  logic          rd_valid;
  logic [CB-1:0] snake_head_x;
  logic [CB-1:0] snake_head_y;
  logic [LB-1:0] snake_length;
  logic          busy;
  logic          collision_detected;

  always #20 clock_25 = ~clock_25;

  snake_body_engine dut (
    .clock_25           (clock_25),
    .reset              (reset),
    .game_tik           (game_tik),
    .dir_req            (dir_req),
    .fruit_eaten        (fruit_eaten),
    .rd_index           (rd_index),
    .rd_x               (rd_x),
    .rd_y               (rd_y),
    .rd_valid           (rd_valid),
    .snake_head_x       (snake_head_x),
    .snake_head_y       (snake_head_y),
    .snake_length       (snake_length),
    .busy               (busy),
    .collision_detected (collision_detected)
  );

  typedef struct { int hx; int hy; int len; int coll; int bcyc; } move_exp_t;
  typedef struct { int idx; int x; int y; int v; } rd_exp_t;

  move_exp_t move_q[$];
  rd_exp_t   rd_q[$];
  int checks = 0;
  int errors = 0;

  // Reference snake: element 0 is the head.
  int       mx[ML];
  int       my[ML];
  int       mlen;
  logic [1:0] mdir;
  bit       mgrow;
  bit       mcoll;

  bit rd_strobe = 1'b0;
  bit rd_cap    = 1'b0;
  int bcount    = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < ML; i++) begin
      mx[i] = SX - i;
      my[i] = SY;
    end
    mlen  = IL;
    mdir  = DIR_RIGHT;
    mgrow = 1'b0;
    mcoll = 1'b0;
  endtask

  function automatic logic [1:0] modelEffDir(input logic [1:0] req);
    logic [1:0] back;
    case (mdir)
      DIR_RIGHT: back = DIR_LEFT;
      DIR_LEFT:  back = DIR_RIGHT;
      DIR_UP:    back = DIR_DOWN;
      default:   back = DIR_UP;
    endcase
    return (req == back) ? mdir : req;
  endfunction

  task automatic modelMove(input logic [1:0] req, input bit fruit, output int bcyc);
    int nx, ny, hit;
    bit wall;
    logic [1:0] d;
    move_exp_t e;
    if (fruit) mgrow = 1'b1;
    bcyc = 0;
    if (mcoll) return;
    d  = modelEffDir(req);
    nx = mx[0];
    ny = my[0];
    case (d)
      DIR_RIGHT: nx = nx + 1;
      DIR_LEFT:  nx = nx - 1;
      DIR_UP:    ny = ny - 1;
      default:   ny = ny + 1;
    endcase
    wall = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
`ifdef SNAKE_WRAP_AROUND_EN
    if (wall) begin
      nx   = (nx + GW) % GW;
      ny   = (ny + GH) % GH;
      wall = 1'b0;
    end
`endif
    if (wall) begin
      mcoll = 1'b1;
      bcyc  = 1;
    end else begin
      for (int i = ML - 1; i > 0; i--) begin
        mx[i] = mx[i-1];
        my[i] = my[i-1];
      end
      mx[0] = nx;
      my[0] = ny;
      mdir  = d;
      if (mgrow) begin
        if (mlen < ML) mlen++;
        mgrow = 1'b0;
      end
      hit = 0;
      for (int i = 1; i < mlen; i++)
        if (hit == 0 && mx[i] == nx && my[i] == ny) hit = i;
      if (hit != 0) begin
        mcoll = 1'b1;
        bcyc  = 1 + hit;
      end else begin
        bcyc = 1 + mlen;
      end
    end
    e.hx = mx[0]; e.hy = my[0]; e.len = mlen; e.coll = int'(mcoll); e.bcyc = bcyc;
    move_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [1:0] d, input bit fruit, input bit tik);
    int bcyc;
    if (tik) modelMove(d, fruit, bcyc);
    else begin
      if (fruit) mgrow = 1'b1;
      bcyc = 0;
    end
    @(posedge clock_25); #1;
    dir_req     = d;
    fruit_eaten = fruit;
    game_tik    = tik;
    @(posedge clock_25); #1;
    fruit_eaten = 1'b0;
    game_tik    = 1'b0;
    repeat (bcyc + 2) @(posedge clock_25);
  endtask

  task automatic readOne(input int idx);
    rd_exp_t e;
    @(posedge clock_25); #1;
    rd_index  = LB'(idx);
    rd_strobe = 1'b1;
    e.idx = idx;
    if (idx < mlen) begin
      e.x = mx[idx]; e.y = my[idx]; e.v = 1;
    end else begin
      e.x = 0; e.y = 0; e.v = 0;
    end
    rd_q.push_back(e);
  endtask

  task automatic readEnd();
    @(posedge clock_25); #1;
    rd_strobe = 1'b0;
    @(posedge clock_25); #1;
  endtask

  task automatic readRange(input int first, input int last);
    for (int i = first; i <= last; i++) readOne(i);
    readEnd();
  endtask

  task automatic readRandom(input int n);
    for (int i = 0; i < n; i++) readOne(int'($urandom_range(0, 63)));
    readEnd();
  endtask

  task automatic applyReset();
    @(posedge clock_25); #1;
    reset       = 1'b1;
    game_tik    = 1'b0;
    fruit_eaten = 1'b0;
    rd_strobe   = 1'b0;
    repeat (2) @(posedge clock_25);
    @(negedge clock_25);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_coll", int'(collision_detected), 0);
    checkOutput("rst_len", int'(snake_length), IL);
    checkOutput("rst_head_x", int'(snake_head_x), SX);
    checkOutput("rst_head_y", int'(snake_head_y), SY);
    checkOutput("rst_rd_valid", int'(rd_valid), 0);
    checkOutput("rst_rd_x", int'(rd_x), 0);
    checkOutput("rst_pending_moves", move_q.size(), 0);
    move_q.delete();
    rd_q.delete();
    @(posedge clock_25); #1;
    reset = 1'b0;
    modelReset();
  endtask

  always @(posedge clock_25) rd_cap <= rd_strobe;

  // Read monitor: one result per strobed read, one cycle later.
  always @(negedge clock_25) begin
    rd_exp_t e;
    if (rd_cap) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rd_unexpected actual=data expected=none");
      end else begin
        e = rd_q.pop_front();
        checkOutput($sformatf("rd_valid[%0d]", e.idx), int'(rd_valid), e.v);
        checkOutput($sformatf("rd_x[%0d]", e.idx), int'(rd_x), e.x);
        checkOutput($sformatf("rd_y[%0d]", e.idx), int'(rd_y), e.y);
      end
    end
  end

  // Move monitor: each busy window must match the next queued move.
  always @(negedge clock_25) begin
    move_exp_t e;
    if (reset) begin
      bcount = 0;
    end else if (busy) begin
      bcount++;
    end else if (bcount > 0) begin
      if (move_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL move_unexpected actual=busy_pulse_%0d expected=none", bcount);
      end else begin
        e = move_q.pop_front();
        checkOutput("move_head_x", int'(snake_head_x), e.hx);
        checkOutput("move_head_y", int'(snake_head_y), e.hy);
        checkOutput("move_len", int'(snake_length), e.len);
        checkOutput("move_coll", int'(collision_detected), e.coll);
        checkOutput("move_busy_cycles", bcount, e.bcyc);
      end
      bcount = 0;
    end
  end

  initial begin
    #(60000 * 40);
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bcyc;
    int t;
    logic [1:0] d;
    reset       = 1'b1;
    game_tik    = 1'b0;
    fruit_eaten = 1'b0;
    dir_req     = DIR_RIGHT;
    rd_index    = '0;

    applyReset();
    readRange(0, 3);

    applyStimulus(DIR_UP, 1'b0, 1'b1);
    readRange(0, 3);
    applyStimulus(DIR_RIGHT, 1'b1, 1'b1);
    readRange(0, 4);
    applyStimulus(DIR_LEFT, 1'b0, 1'b1);
    readRange(0, 1);
    applyStimulus(DIR_RIGHT, 1'b1, 1'b1);
    applyStimulus(DIR_UP, 1'b0, 1'b1);
    applyStimulus(DIR_LEFT, 1'b0, 1'b1);
    applyStimulus(DIR_DOWN, 1'b0, 1'b1);
    checkOutput("self_coll_flag", int'(collision_detected), int'(mcoll));
    applyStimulus(DIR_RIGHT, 1'b0, 1'b1);
    checkOutput("halt_head_x", int'(snake_head_x), mx[0]);
    checkOutput("halt_head_y", int'(snake_head_y), my[0]);
    checkOutput("halt_busy", int'(busy), 0);
    readRange(0, 5);

    applyReset();

    // Second tik lands in CHECK and must vanish.
    modelMove(DIR_UP, 1'b0, bcyc);
    @(posedge clock_25); #1;
    dir_req  = DIR_UP;
    game_tik = 1'b1;
    @(posedge clock_25); #1;
    game_tik = 1'b0;
    @(posedge clock_25); #1;
    dir_req  = DIR_LEFT;
    game_tik = 1'b1;
    @(posedge clock_25); #1;
    game_tik = 1'b0;
    repeat (bcyc + 2) @(posedge clock_25);
    readRange(0, 2);

    for (int n = 0; n < 150; n++) begin
      d = 2'($urandom_range(0, 3));
      applyStimulus(d, ($urandom_range(0, 3) == 0), 1'b1);
      if ($urandom_range(0, 3) == 0) readRandom(4);
      if (mcoll) begin
        checkOutput("rand_coll_flag", int'(collision_detected), 1);
        applyReset();
      end
    end

    applyReset();
    for (int n = 0; n < ML - IL; n++) applyStimulus(DIR_RIGHT, 1'b1, 1'b1);
    checkOutput("len_at_max", int'(snake_length), ML);
    applyStimulus(DIR_RIGHT, 1'b1, 1'b1);
    checkOutput("len_saturated", int'(snake_length), ML);
    readRange(28, 33);
    while (mx[0] < GW - 1) applyStimulus(DIR_RIGHT, 1'b0, 1'b1);
    applyStimulus(DIR_RIGHT, 1'b0, 1'b1);
`ifdef SNAKE_WRAP_AROUND_EN
    checkOutput("edge_wrap_x", int'(snake_head_x), 0);
    checkOutput("edge_wrap_coll", int'(collision_detected), 0);
`else
    checkOutput("edge_wall_x", int'(snake_head_x), GW - 1);
    checkOutput("edge_wall_coll", int'(collision_detected), 1);
`endif
    readRange(0, 2);

    t = 0;
    while ((move_q.size() != 0 || rd_q.size() != 0) && t < 200) begin
      @(posedge clock_25);
      t++;
    end
    checkOutput("drain_queues", move_q.size() + rd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
